// File: rtl/seq_window_counter_if.sv
// Bundles the serial-input qualification and window-count results of seq_window_counter.
// The master drives the stream; the slave (the counter) reports window status and count.
interface seq_window_counter_if #(
    parameter int CNT_W = 7
);
    logic             in_i;
    logic             in_valid_i;
    logic             clear_i;
    logic             active_o;
    logic             done_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;

    modport master (
        output in_i, in_valid_i, clear_i,
        input  active_o, done_o, count_o, overflow_o
    );

    modport slave (
        input  in_i, in_valid_i, clear_i,
        output active_o, done_o, count_o, overflow_o
    );
endinterface

// File: rtl/seq_window_counter.sv
// Serial pattern-window counter: START opens a window, CNT_PAT matches are counted
// with saturation, STOP closes it. Feeds the two-digit 7-segment display path.
module seq_window_counter #(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] START_PAT = 4'b1001,
    parameter logic [PAT_W-1:0] STOP_PAT  = 4'b1001,
    parameter logic [PAT_W-1:0] CNT_PAT   = 4'b0110,
    parameter int               CNT_W     = 7,
    parameter int               CNT_MAX   = 99,
    parameter int               REARM     = 0
) (
    input  logic                clk,
    input  logic                reset,
    seq_window_counter_if.slave bus
);
    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  history_q, history_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;

    logic [PAT_W-1:0]  win;
    logic              eligible;
    logic              stop_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            history_q  <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            history_q  <= history_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // The match window includes the sample being taken on this edge.
    always_comb begin
        state_d    = state_q;
        history_d  = history_q;
        fill_d     = fill_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        stop_hit   = 1'b0;
        win        = {history_q[PAT_W-2:0], bus.in_i};
        eligible   = bus.in_valid_i && (fill_q == FILL_FULL);

        if (bus.clear_i) begin
            state_d    = ST_IDLE;
            history_d  = '0;
            fill_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (bus.in_valid_i) begin
            history_d = win;
            if (fill_q != FILL_FULL) begin
                fill_d = FILL_W'(fill_q + 1'b1);
            end
            if (eligible) begin
                case (state_q)
                    ST_IDLE: begin
                        // The opening window is consumed here and never counted or treated as STOP.
                        if (win == START_PAT) begin
                            state_d    = ST_ACTIVE;
                            count_d    = '0;
                            overflow_d = 1'b0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (win == CNT_PAT) begin
                            if (count_q < CNT_SAT) begin
                                count_d = CNT_W'(count_q + 1'b1);
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                        if (win == STOP_PAT) begin
                            state_d  = (REARM != 0) ? ST_IDLE : ST_DONE;
                            stop_hit = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        done_d = (REARM != 0) ? stop_hit : (state_d == ST_DONE);
    end

    assign bus.active_o   = (state_q == ST_ACTIVE);
    assign bus.done_o     = done_q;
    assign bus.count_o    = count_q;
    assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_seq_window_counter.sv
// Drives one stream into three counter configurations and checks them against a
// sample-history reference model, a vector table and hand-written corner sequences.
module tb_seq_window_counter;
    localparam int START_V = 9;
    localparam int STOP_V  = 9;
    localparam int CNT_V   = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_b = 1'b0;
    logic vld = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    seq_window_counter_if #(.CNT_W(7)) if0 ();
    seq_window_counter_if #(.CNT_W(7)) if1 ();
    seq_window_counter_if #(.CNT_W(7)) if2 ();

    assign if0.in_i = in_b; assign if0.in_valid_i = vld; assign if0.clear_i = clr;
    assign if1.in_i = in_b; assign if1.in_valid_i = vld; assign if1.clear_i = clr;
    assign if2.in_i = in_b; assign if2.in_valid_i = vld; assign if2.clear_i = clr;

    seq_window_counter #(.REARM(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    seq_window_counter #(.REARM(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    seq_window_counter #(.REARM(1), .CNT_MAX(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: keeps the recent valid samples and applies the window rules directly.
    int rearm_p [3] = '{0, 1, 1};
    int cmax_p  [3] = '{99, 99, 2};
    int m_state [3];          // 0 idle, 1 window open, 2 finished
    int m_count [3];
    bit m_ovf   [3];
    bit m_done  [3];
    bit samples [$];

    function automatic void model_reset();
        samples.delete();
        for (int p = 0; p < 3; p++) begin
            m_state[p] = 0; m_count[p] = 0; m_ovf[p] = 0; m_done[p] = 0;
        end
    endfunction

    function automatic void model_step();
        int w;
        bit stop;
        if (!reset || clr) begin
            model_reset();
            return;
        end
        if (!vld) begin
            for (int p = 0; p < 3; p++) m_done[p] = (rearm_p[p] != 0) ? 1'b0 : (m_state[p] == 2);
            return;
        end
        samples.push_back(in_b);
        if (samples.size() > 4) void'(samples.pop_front());
        w = -1;
        if (samples.size() == 4) begin
            w = 0;
            for (int k = 0; k < 4; k++) w = w * 2 + int'(samples[k]);
        end
        for (int p = 0; p < 3; p++) begin
            stop = 0;
            if (m_state[p] == 0 && w == START_V) begin
                m_state[p] = 1; m_count[p] = 0; m_ovf[p] = 0;
            end else if (m_state[p] == 1 && w >= 0) begin
                if (w == CNT_V) begin
                    if (m_count[p] < cmax_p[p]) m_count[p]++;
                    else m_ovf[p] = 1;
                end
                if (w == STOP_V) begin
                    stop = 1;
                    m_state[p] = (rearm_p[p] != 0) ? 0 : 2;
                end
            end
            m_done[p] = (rearm_p[p] != 0) ? stop : (m_state[p] == 2);
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("m0_active", int'(if0.active_o), int'(m_state[0] == 1));
        chk("m0_done", int'(if0.done_o), int'(m_done[0]));
        chk("m0_count", int'(if0.count_o), m_count[0]);
        chk("m0_ovf", int'(if0.overflow_o), int'(m_ovf[0]));
        chk("m1_active", int'(if1.active_o), int'(m_state[1] == 1));
        chk("m1_done", int'(if1.done_o), int'(m_done[1]));
        chk("m1_count", int'(if1.count_o), m_count[1]);
        chk("m1_ovf", int'(if1.overflow_o), int'(m_ovf[1]));
        chk("m2_active", int'(if2.active_o), int'(m_state[2] == 1));
        chk("m2_done", int'(if2.done_o), int'(m_done[2]));
        chk("m2_count", int'(if2.count_o), m_count[2]);
        chk("m2_ovf", int'(if2.overflow_o), int'(m_ovf[2]));
    endtask

    task automatic step(input bit b, input bit v, input bit c);
        @(negedge clk);
        in_b = b; vld = v; clr = c;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        $display("cyc=%0d rst=%0b in=%0b v=%0b clr=%0b | d0 a=%0b d=%0b c=%0d o=%0b | d1 a=%0b d=%0b c=%0d o=%0b | d2 a=%0b d=%0b c=%0d o=%0b",
                 cyc, reset, b, v, c,
                 if0.active_o, if0.done_o, if0.count_o, if0.overflow_o,
                 if1.active_o, if1.done_o, if1.count_o, if1.overflow_o,
                 if2.active_o, if2.done_o, if2.count_o, if2.overflow_o);
        compare_model();
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) step(bits[k], 1'b1, 1'b0);
    endtask

    typedef struct {
        bit b; bit v; bit c;
        bit e_active; bit e_done; int e_count; bit e_ovf;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(bit b, bit v, bit c, bit ea, bit ed, int ec, bit eo);
        vec_t r;
        r.b = b; r.v = v; r.c = c; r.e_active = ea; r.e_done = ed; r.e_count = ec; r.e_ovf = eo;
        tbl.push_back(r);
    endfunction

    initial begin
        model_reset();
        // Incomplete fill, then clear, then a start with overlapping count and stop (REARM=0 unit).
        add(1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 0, 1, 0);
        add(1, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 1, 1, 0);
        // Gapped start: invalid cycles carry garbage that must not be sampled.
        add(0, 1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_active", int'(if0.active_o), 0);
        chk("reset_done", int'(if0.done_o), 0);
        chk("reset_count", int'(if0.count_o), 0);
        chk("reset_ovf", int'(if0.overflow_o), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].b, tbl[i].v, tbl[i].c);
            chk($sformatf("tbl%0d_active", i), int'(if0.active_o), int'(tbl[i].e_active));
            chk($sformatf("tbl%0d_done", i), int'(if0.done_o), int'(tbl[i].e_done));
            chk($sformatf("tbl%0d_count", i), int'(if0.count_o), tbl[i].e_count);
            chk($sformatf("tbl%0d_ovf", i), int'(if0.overflow_o), int'(tbl[i].e_ovf));
        end

        // Re-arm and saturation: three counts, stop, one-cycle done pulse, restart.
        step(0, 1, 1);
        feed(16'b1001, 4);
        chk("rearm_start", int'(if1.active_o), 1);
        feed(16'b10, 2);
        feed(16'b110110, 6);
        chk("rearm_count3", int'(if1.count_o), 3);
        chk("sat_count", int'(if2.count_o), 2);
        chk("sat_ovf", int'(if2.overflow_o), 1);
        feed(16'b01, 2);
        chk("stop_done_pulse", int'(if1.done_o), 1);
        chk("stop_inactive", int'(if1.active_o), 0);
        chk("stop_level_done", int'(if0.done_o), 1);
        step(1, 0, 0);
        chk("pulse_one_cycle", int'(if1.done_o), 0);
        chk("rearm_count_hold", int'(if1.count_o), 3);
        feed(16'b001, 3);
        chk("restart_active", int'(if1.active_o), 1);
        chk("restart_count", int'(if1.count_o), 0);
        chk("restart_ovf", int'(if2.overflow_o), 0);
        chk("done_absorbing", int'(if0.done_o), 1);

        // Asynchronous reset mid-window with count=5.
        step(0, 1, 1);
        feed(16'b1001, 4);
        feed(16'b10, 2);
        feed(16'b110110110110, 12);
        chk("pre_reset_count", int'(if0.count_o), 5);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_count", int'(if0.count_o), 0);
        chk("async_active", int'(if0.active_o), 0);
        step(1, 1, 0);
        @(negedge clk);
        reset = 1'b1;

        // Clear out of the finished state.
        feed(16'b1001001, 7);
        chk("pre_clear_done", int'(if0.done_o), 1);
        step(1, 1, 1);
        chk("clear_done", int'(if0.done_o), 0);
        chk("clear_count", int'(if0.count_o), 0);
        chk("clear_active", int'(if0.active_o), 0);

        // Random stream against the model.
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
